// File: rtl/audio_pkg.sv
// Shared definitions for the audio processing path (mic decimator and
// downstream consumers such as the level meter).
//   - DEFAULT_SAMPLE_DEPTH : PCM sample width produced by the decimator
//   - meter_state_t        : level-meter sequencing states
//   - sat_max / sat_min    : saturation limits of a signed N-bit value
package audio_pkg;

    localparam int DEFAULT_SAMPLE_DEPTH = 16;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_DCB  = 3'd1,
        ST_MAG  = 3'd2,
        ST_ACC  = 3'd3,
        ST_EMIT = 3'd4
    } meter_state_t;

    // Largest value representable in a signed field of 'width' bits.
    function automatic int sat_max(input int width);
        return (1 <<< (width - 1)) - 1;
    endfunction

    // Smallest value representable in a signed field of 'width' bits.
    function automatic int sat_min(input int width);
        return -(1 <<< (width - 1));
    endfunction

endpackage

// File: rtl/dc_blocker.sv
// First-order DC-blocking high-pass. The DC estimate is a leaky integrator
// dc_acc with time constant 2^DC_SHIFT samples; each strobe removes the
// current estimate from x (saturated) and folds x into the estimate.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   i_strobe  : process i_x this cycle
//   i_x       : signed input sample
//   o_y       : signed, saturated, DC-removed sample (registered on strobe)
module dc_blocker
    import audio_pkg::*;
#(
    parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
    parameter int DC_SHIFT     = 6
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           i_strobe,
    input  logic signed [SAMPLE_DEPTH-1:0] i_x,
    output logic signed [SAMPLE_DEPTH-1:0] o_y
);

    localparam int AW = SAMPLE_DEPTH + DC_SHIFT;
    localparam logic signed [SAMPLE_DEPTH:0] Y_MAX = (SAMPLE_DEPTH+1)'(sat_max(SAMPLE_DEPTH));
    localparam logic signed [SAMPLE_DEPTH:0] Y_MIN = (SAMPLE_DEPTH+1)'(sat_min(SAMPLE_DEPTH));

    logic signed [AW-1:0]           r_dc_acc;
    logic signed [SAMPLE_DEPTH-1:0] r_y;
    logic signed [SAMPLE_DEPTH-1:0] w_dc;
    logic signed [SAMPLE_DEPTH:0]   w_diff;
    logic signed [SAMPLE_DEPTH-1:0] w_y_sat;

    // The accumulator holds 2^DC_SHIFT times the running mean, so its
    // arithmetic shift is itself a valid SAMPLE_DEPTH-bit sample.
    assign w_dc   = SAMPLE_DEPTH'(r_dc_acc >>> DC_SHIFT);
    assign w_diff = (SAMPLE_DEPTH+1)'(i_x) - (SAMPLE_DEPTH+1)'(w_dc);

    always_comb begin
        w_y_sat = w_diff[SAMPLE_DEPTH-1:0];
        if (w_diff > Y_MAX) begin
            w_y_sat = Y_MAX[SAMPLE_DEPTH-1:0];
        end else if (w_diff < Y_MIN) begin
            w_y_sat = Y_MIN[SAMPLE_DEPTH-1:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dc_acc <= '0;
            r_y      <= '0;
        end else if (i_strobe) begin
            // Leak uses the unsaturated difference so the estimate converges.
            r_dc_acc <= r_dc_acc + AW'(i_x) - AW'(w_dc);
            r_y      <= w_y_sat;
        end
    end

    assign o_y = r_y;

endmodule

// File: rtl/audio_level_meter.sv
// Sound-level meter: DC block -> rectify -> windowed max-hold, emitting one
// level per WINDOW samples plus a peak value that is held for HOLD_WINDOWS
// windows and then decays. One sample is processed per IDLE->DCB->MAG->ACC
// (->EMIT) pass; samples arriving while busy are dropped and flagged.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   audio       : signed PCM sample, qualified by audio_valid
//   level       : most recent window level (top LEVEL_WIDTH magnitude bits)
//   level_valid : one-cycle pulse when level/peak update
//   peak        : peak-hold/decay value
//   overrun     : sticky, a sample arrived while the pipeline was busy
module audio_level_meter
    import audio_pkg::*;
#(
    parameter int SAMPLE_DEPTH = DEFAULT_SAMPLE_DEPTH,
    parameter int LEVEL_WIDTH  = 8,
    parameter int DC_SHIFT     = 6,
    parameter int WINDOW       = 256,
    parameter int HOLD_WINDOWS = 4,
    parameter int DECAY_SHIFT  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [SAMPLE_DEPTH-1:0] audio,
    input  logic                           audio_valid,
    output logic [LEVEL_WIDTH-1:0]         level,
    output logic                           level_valid,
    output logic [LEVEL_WIDTH-1:0]         peak,
    output logic                           overrun
);

    localparam int MW = SAMPLE_DEPTH - 1;
    localparam int CW = $clog2(WINDOW);
    localparam int HW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam logic signed [SAMPLE_DEPTH-1:0] Y_MIN = SAMPLE_DEPTH'(sat_min(SAMPLE_DEPTH));

    meter_state_t                   r_state;
    meter_state_t                   w_state_next;
    logic signed [SAMPLE_DEPTH-1:0] r_x;
    logic signed [SAMPLE_DEPTH-1:0] w_y;
    logic [MW-1:0]                  w_mag;
    logic [MW-1:0]                  r_mag;
    logic [MW-1:0]                  r_win_max;
    logic [CW-1:0]                  r_win_count;
    logic [LEVEL_WIDTH-1:0]         r_level;
    logic                           r_level_valid;
    logic [LEVEL_WIDTH-1:0]         r_peak;
    logic [HW-1:0]                  r_hold_cnt;
    logic                           r_overrun;

    logic w_capture, w_dcb_stb, w_mag_stb, w_acc_stb, w_emit_stb, w_drop;
    logic w_win_last;
    logic [LEVEL_WIDTH-1:0] w_level_new, w_decay, w_step, w_peak_next;
    logic [HW-1:0]          w_hold_next;

    assign w_win_last = (r_win_count == CW'(WINDOW - 1));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE: if (audio_valid) w_state_next = ST_DCB;
            ST_DCB:  w_state_next = ST_MAG;
            ST_MAG:  w_state_next = ST_ACC;
            ST_ACC:  w_state_next = w_win_last ? ST_EMIT : ST_IDLE;
            ST_EMIT: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State-decoded strobes
    always_comb begin
        w_capture  = (r_state == ST_IDLE) && audio_valid;
        w_dcb_stb  = (r_state == ST_DCB);
        w_mag_stb  = (r_state == ST_MAG);
        w_acc_stb  = (r_state == ST_ACC);
        w_emit_stb = (r_state == ST_EMIT);
        w_drop     = (r_state != ST_IDLE) && audio_valid;
    end

    dc_blocker #(
        .SAMPLE_DEPTH (SAMPLE_DEPTH),
        .DC_SHIFT     (DC_SHIFT)
    ) u_dc_blocker (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (w_dcb_stb),
        .i_x      (r_x),
        .o_y      (w_y)
    );

    // |y| fits MW bits for every y except the most negative, which clamps.
    assign w_mag = (w_y == Y_MIN) ? {MW{1'b1}}
                                  : MW'(w_y[SAMPLE_DEPTH-1] ? -w_y : w_y);

    // Peak tracker, evaluated against the level being emitted.
    assign w_level_new = r_win_max[MW-1 -: LEVEL_WIDTH];
    assign w_decay     = r_peak >> DECAY_SHIFT;
    assign w_step      = (w_decay == '0) ? LEVEL_WIDTH'(1) : w_decay;

    always_comb begin
        w_peak_next = r_peak;
        w_hold_next = r_hold_cnt;
        if (w_level_new >= r_peak) begin
            w_peak_next = w_level_new;
            w_hold_next = HW'(HOLD_WINDOWS);
        end else if (r_hold_cnt != '0) begin
            w_hold_next = r_hold_cnt - HW'(1);
        end else begin
            // level < peak here, so peak is non-zero and step <= peak.
            w_peak_next = r_peak - w_step;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x           <= '0;
            r_mag         <= '0;
            r_win_max     <= '0;
            r_win_count   <= '0;
            r_level       <= '0;
            r_level_valid <= 1'b0;
            r_peak        <= '0;
            r_hold_cnt    <= '0;
            r_overrun     <= 1'b0;
        end else begin
            r_level_valid <= w_emit_stb;
            if (w_capture) begin
                r_x <= audio;
            end
            if (w_mag_stb) begin
                r_mag <= w_mag;
            end
            if (w_acc_stb) begin
                if (r_mag > r_win_max) begin
                    r_win_max <= r_mag;
                end
                if (!w_win_last) begin
                    r_win_count <= r_win_count + CW'(1);
                end
            end
            if (w_emit_stb) begin
                r_level     <= w_level_new;
                r_peak      <= w_peak_next;
                r_hold_cnt  <= w_hold_next;
                r_win_max   <= '0;
                r_win_count <= '0;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end
        end
    end

    assign level       = r_level;
    assign level_valid = r_level_valid;
    assign peak        = r_peak;
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_audio_level_meter.sv
module tb_audio_level_meter;

    localparam int W    = 4;
    localparam int HOLD = 2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic signed [15:0] audio = '0;
    logic               audio_valid = 1'b0;
    logic [7:0]         level;
    logic               level_valid;
    logic [7:0]         peak;
    logic               overrun;

    audio_level_meter #(
        .SAMPLE_DEPTH (16),
        .LEVEL_WIDTH  (8),
        .DC_SHIFT     (6),
        .WINDOW       (W),
        .HOLD_WINDOWS (HOLD),
        .DECAY_SHIFT  (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .audio       (audio),
        .audio_valid (audio_valid),
        .level       (level),
        .level_valid (level_valid),
        .peak        (peak),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every level_valid pulse is logged with the edge it followed.
    typedef struct {
        int level;
        int peak;
        int edge_no;
    } emit_t;
    emit_t lv_q[$];
    int    lv_count = 0;
    always @(negedge clk) begin
        if (level_valid) begin
            lv_q.push_back('{int'(level), int'(peak), cyc});
            lv_count <= lv_count + 1;
        end
    end

    int errors = 0;
    int checks = 0;
    int rd_idx = 0;
    int last_valid_edge = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    longint m_acc;
    int     m_winmax, m_count, m_level, m_peak, m_hold;

    task automatic model_reset();
        m_acc = 0; m_winmax = 0; m_count = 0;
        m_level = 0; m_peak = 0; m_hold = 0;
    endtask

    task automatic model_sample(input int x, output bit emit);
        longint dc, y, mag;
        int step;
        dc = m_acc >>> 6;                       // floor(acc / 64)
        y  = x - dc;
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
        m_acc = m_acc + x - dc;
        mag = (y < 0) ? -y : y;
        if (mag > 32767) mag = 32767;
        if (mag > m_winmax) m_winmax = int'(mag);
        emit = 1'b0;
        if (m_count == W - 1) begin
            emit    = 1'b1;
            m_level = m_winmax / 128;
            if (m_level >= m_peak) begin
                m_peak = m_level;
                m_hold = HOLD;
            end else if (m_hold != 0) begin
                m_hold--;
            end else if (m_peak != 0) begin
                step = m_peak / 16;
                if (step < 1) step = 1;
                m_peak -= step;
            end
            m_winmax = 0;
            m_count  = 0;
        end else begin
            m_count++;
        end
    endtask

    // ---------------- stimulus helpers (called at a negedge) ----------------
    task automatic do_reset();
        rst = 1'b1;
        audio_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        rd_idx = lv_q.size();
        model_reset();
    endtask

    // Valid is sampled at the next posedge; returns 'gap' cycles later.
    task automatic send(input int x, input int gap);
        audio = 16'(x);
        audio_valid = 1'b1;
        last_valid_edge = cyc + 1;
        @(negedge clk);
        audio_valid = 1'b0;
        repeat (gap - 1) @(negedge clk);
    endtask

    // exp_level < 0 skips the level comparison.
    task automatic expect_emit(input string name, input int exp_level, input int exp_peak,
                               output int edge_no);
        int waited = 0;
        edge_no = -1;
        while (rd_idx >= lv_q.size() && waited < 30) begin
            @(negedge clk);
            waited++;
        end
        check({name, "_emit_seen"}, (rd_idx < lv_q.size()) ? 1 : 0, 1);
        if (rd_idx < lv_q.size()) begin
            if (exp_level >= 0) check({name, "_level"}, lv_q[rd_idx].level, exp_level);
            check({name, "_peak"}, lv_q[rd_idx].peak, exp_peak);
            edge_no = lv_q[rd_idx].edge_no;
            rd_idx++;
        end
    endtask

    // Send through both DUT and model; compare whenever the model emits.
    task automatic send_m(input int x, input int gap, input string name);
        bit e;
        int en;
        send(x, gap);
        model_sample(x, e);
        if (e) expect_emit(name, m_level, m_peak, en);
    endtask

    task automatic zero_window(input string name, input int exp_level, input int exp_peak);
        int en;
        for (int i = 0; i < W; i++) send(0, 6);
        expect_emit(name, exp_level, exp_peak, en);
    endtask

    // ---------------- table of single-impulse windows ----------------
    typedef struct {
        int    s0;
        int    exp_level;
        int    exp_peak;
        string name;
    } vec_t;
    vec_t vecs[8];

    initial begin
        int en, base, x;

        vecs[0] = '{32767,  255, 255, "tbl_pos_full"};
        vecs[1] = '{-32768, 255, 255, "tbl_neg_full"};
        vecs[2] = '{1000,   7,   7,   "tbl_1000"};
        vecs[3] = '{-1000,  7,   7,   "tbl_m1000"};
        vecs[4] = '{128,    1,   1,   "tbl_128"};
        vecs[5] = '{127,    0,   0,   "tbl_127"};
        vecs[6] = '{16384,  128, 128, "tbl_16384"};
        vecs[7] = '{-256,   2,   2,   "tbl_m256"};

        @(negedge clk);
        repeat (2) @(negedge clk);
        check("reset_level", level, 0);
        check("reset_peak", peak, 0);
        check("reset_level_valid", level_valid, 0);
        check("reset_overrun", overrun, 0);

        // Table-driven: one impulse then zeros, fresh reset each time.
        for (int v = 0; v < 8; v++) begin
            do_reset();
            send(vecs[v].s0, 6);
            for (int i = 1; i < W; i++) send(0, 6);
            expect_emit(vecs[v].name, vecs[v].exp_level, vecs[v].exp_peak, en);
        end

        // Zero input: pulse exactly 4 edges after the closing valid, one cycle wide.
        do_reset();
        base = lv_count;
        for (int i = 0; i < W; i++) send(0, 10);
        check("zero_pulse_count", lv_count - base, 1);
        expect_emit("zero", 0, 0, en);
        check("zero_latency", en - last_valid_edge, 4);
        check("zero_overrun", overrun, 0);

        // Peak hold then decay after a full-scale window.
        do_reset();
        send(-32768, 6);
        for (int i = 1; i < W; i++) send(0, 6);
        expect_emit("hold_fs", 255, 255, en);
        zero_window("hold_w1", -1, 255);
        zero_window("hold_w2", -1, 255);
        zero_window("decay_w3", -1, 240);
        zero_window("decay_w4", -1, 225);
        zero_window("decay_w5", -1, 211);

        // Small peak decays by 1 per window once hold expires.
        do_reset();
        send(1280, 6);
        for (int i = 1; i < W; i++) send(0, 6);
        expect_emit("p10", 10, 10, en);
        zero_window("p10_w1", 0, 10);
        zero_window("p10_w2", 0, 10);
        zero_window("p10_w3", 0, 9);
        zero_window("p10_w4", 0, 8);

        // DC removal: constant input converges to ~0.
        do_reset();
        base = lv_count;
        for (int i = 0; i < W; i++) send(1000, 5);
        expect_emit("dc_first", 7, 7, en);
        for (int i = W; i < 64 * W; i++) send(1000, 5);
        repeat (6) @(negedge clk);
        check("dc_window_count", lv_count - base, 64);
        check("dc_final_level_le1", (lv_q[lv_q.size()-1].level <= 1) ? 1 : 0, 1);
        rd_idx = lv_q.size();

        // Overrun: second valid two cycles later is dropped.
        do_reset();
        base = lv_count;
        send(100, 2);
        send(0, 6);
        check("ovr_flag", overrun, 1);
        send(0, 6);
        send(0, 6);
        repeat (4) @(negedge clk);
        check("ovr_no_emit_after_3", lv_count - base, 0);
        send(0, 6);
        check("ovr_emit_after_4", lv_count - base, 1);
        expect_emit("ovr", 0, 0, en);
        zero_window("ovr_next", 0, 0);
        check("ovr_sticky", overrun, 1);
        do_reset();
        check("ovr_cleared", overrun, 0);

        // Reset mid-window: outputs clear immediately; partial window discarded.
        do_reset();
        send(-32768, 6);
        for (int i = 1; i < W; i++) send(0, 6);
        expect_emit("mid_pre", 255, 255, en);
        send(5000, 6);
        send(-7000, 6);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_peak", peak, 0);
        check("mid_rst_overrun", overrun, 0);
        @(negedge clk);
        do_reset();
        base = lv_count;
        send_m(3000, 6, "mid_post");
        send_m(-200, 6, "mid_post");
        send_m(50, 6, "mid_post");
        send_m(7, 6, "mid_post");
        repeat (4) @(negedge clk);
        check("mid_post_pulse_count", lv_count - base, 1);

        // Randomised windows against the reference model.
        do_reset();
        for (int i = 0; i < 40 * W; i++) begin
            if ($urandom_range(0, 3) == 0) x = int'($urandom_range(0, 65535)) - 32768;
            else x = int'($urandom_range(0, 8191)) - 4096;
            send_m(x, int'($urandom_range(5, 9)), $sformatf("rand_w%0d", i / W));
        end
        check("rand_overrun", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
